// File: rtl/led_pkg.sv
// Shared definitions for the LED bank scanner.
// Holds the default parameter values and the active-low one-hot digit decode
// used to drive the anode enables.
package led_pkg;

   localparam int DEF_NBANKS   = 2;
   localparam int DEF_DIGITS   = 4;
   localparam int DEF_W        = 8;
   localparam int DEF_DWELL    = 100_000_000;
   localparam int DEF_SCAN_DIV = 100_000;

   // One bit of an active-low one-hot decode: bit 'pos' is low only when
   // it is the selected digit 'idx'.
   function automatic logic onehot_n_bit(input int idx, input int pos);
      return (idx != pos);
   endfunction

endpackage

// File: rtl/led_bank_scanner_tick_gen.sv
// tick_gen: modulo-PERIOD cycle counter producing a one-cycle strobe.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset (clears the count)
//   en    - count enable; the count freezes while low
//   clr   - synchronous clear, overrides en
//   tick  - high during the cycle in which the count is PERIOD-1 and en=1
module tick_gen
   import led_pkg::*;
#(
   parameter int PERIOD = DEF_SCAN_DIV
)(
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CW = $clog2(PERIOD);
   localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

   logic [CW-1:0] r_cnt;

   // Strobe is decoded from the count so the consumer acts on the same edge
   // the counter wraps; it only feeds registers in the parent.
   assign tick = en & ~clr & (r_cnt == LAST);

   // Cycle counter: clears on clr, wraps at PERIOD-1, holds while disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= {CW{1'b0}};
      end else if (clr) begin
         r_cnt <= {CW{1'b0}};
      end else if (en) begin
         r_cnt <= tick ? {CW{1'b0}} : r_cnt + CW'(1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

endmodule

// File: rtl/led_bank_scanner.sv
// led_bank_scanner: selects one of NBANKS digit banks (manually or by timed
// auto rotation) and multiplexes its digits onto a shared segment bus.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset (pre-synchronised)
//   in_data    - all banks; bank b digit d at [(b*DIGITS+d)*W +: W]
//   mode       - 0 manual (sel), 1 auto rotation every DWELL cycles
//   sel        - manual bank index; out-of-range values are ignored
//   hold       - freezes auto rotation
//   bank_idx   - displayed bank
//   out_data   - registered digit patterns of the displayed bank
//   seg, an    - scanned digit pattern and active-low digit enable
//   bank_wrap  - one-cycle pulse when rotation wraps to bank 0
module led_bank_scanner
   import led_pkg::*;
#(
   parameter int NBANKS   = DEF_NBANKS,
   parameter int DIGITS   = DEF_DIGITS,
   parameter int W        = DEF_W,
   parameter int DWELL    = DEF_DWELL,
   parameter int SCAN_DIV = DEF_SCAN_DIV,
   localparam int BW      = (NBANKS > 1) ? $clog2(NBANKS) : 1
)(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NBANKS*DIGITS*W-1:0]  in_data,
   input  logic                        mode,
   input  logic [BW-1:0]               sel,
   input  logic                        hold,
   output logic [BW-1:0]               bank_idx,
   output logic [DIGITS*W-1:0]         out_data,
   output logic [W-1:0]                seg,
   output logic [DIGITS-1:0]           an,
   output logic                        bank_wrap
);

   localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [BW:0]   NB_L       = (BW + 1)'(NBANKS);
   localparam logic [BW-1:0] LAST_BANK  = BW'(NBANKS - 1);
   localparam logic [DW-1:0] LAST_DIGIT = DW'(DIGITS - 1);

   logic [BW-1:0]       r_bank;
   logic                r_wrap;
   logic [DIGITS*W-1:0] r_out;
   logic [W-1:0]        r_seg;
   logic [DIGITS-1:0]   r_an;
   logic [DW-1:0]       r_digit;

   logic                w_dwell_en;
   logic                w_dwell_clr;
   logic                w_dwell_tick;
   logic                w_scan_tick;
   logic                w_sel_ok;
   logic [DIGITS-1:0]   w_an_next;
   logic [DIGITS*W-1:0] w_bank_slice [NBANKS];
   logic [W-1:0]        w_digit_pat  [DIGITS];

   // Dwell counter only runs in auto mode and is parked at 0 in manual mode,
   // so entering auto always starts a full dwell period.
   assign w_dwell_en  = mode & ~hold;
   assign w_dwell_clr = ~mode;
   assign w_sel_ok    = ({1'b0, sel} < NB_L);

   tick_gen #(.PERIOD(DWELL)) u_dwell (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (w_dwell_en),
      .clr   (w_dwell_clr),
      .tick  (w_dwell_tick)
   );

   tick_gen #(.PERIOD(SCAN_DIV)) u_scan (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (1'b1),
      .clr   (1'b0),
      .tick  (w_scan_tick)
   );

   for (genvar b = 0; b < NBANKS; b++) begin : g_bank
      assign w_bank_slice[b] = in_data[b*DIGITS*W +: DIGITS*W];
   end

   for (genvar d = 0; d < DIGITS; d++) begin : g_digit
      assign w_digit_pat[d] = r_out[d*W +: W];
   end

   // Active-low one-hot decode of the current scan digit.
   always_comb begin
      w_an_next = {DIGITS{1'b1}};
      for (int i = 0; i < DIGITS; i++) begin
         w_an_next[i] = onehot_n_bit(32'(r_digit), i);
      end
   end

   // Bank selection: manual load of in-range sel, or auto advance on dwell tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bank <= {BW{1'b0}};
         r_wrap <= 1'b0;
      end else begin
         r_wrap <= 1'b0;
         if (!mode) begin
            r_bank <= w_sel_ok ? sel : r_bank;
         end else if (w_dwell_tick) begin
            if (r_bank == LAST_BANK) begin
               r_bank <= {BW{1'b0}};
               r_wrap <= 1'b1;
            end else begin
               r_bank <= r_bank + BW'(1);
            end
         end else begin
            r_bank <= r_bank;
         end
      end
   end

   // Digit scan index advances once per scan slot and wraps after the last digit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_digit <= {DW{1'b0}};
      end else if (w_scan_tick) begin
         r_digit <= (r_digit == LAST_DIGIT) ? {DW{1'b0}} : r_digit + DW'(1);
      end else begin
         r_digit <= r_digit;
      end
   end

   // Output registers: bank data, scanned segment pattern and anode enables.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out <= {(DIGITS*W){1'b0}};
         r_seg <= {W{1'b0}};
         r_an  <= {DIGITS{1'b1}};
      end else begin
         r_out <= w_bank_slice[r_bank];
         r_seg <= w_digit_pat[r_digit];
         r_an  <= w_an_next;
      end
   end

   assign bank_idx  = r_bank;
   assign bank_wrap = r_wrap;
   assign out_data  = r_out;
   assign seg       = r_seg;
   assign an        = r_an;

endmodule

// File: tb/tb_led_bank_scanner.sv
module tb_led_bank_scanner;

   localparam int NBANKS   = 3;
   localparam int DIGITS   = 4;
   localparam int W        = 8;
   localparam int DWELL    = 10;
   localparam int SCAN_DIV = 4;
   localparam int BW       = 2;
   localparam int DBITS    = NBANKS * DIGITS * W;

   logic              clk;
   logic              rst_n;
   logic [DBITS-1:0]  in_data;
   logic              mode;
   logic [BW-1:0]     sel;
   logic              hold;
   logic [BW-1:0]     bank_idx;
   logic [DIGITS*W-1:0] out_data;
   logic [W-1:0]      seg;
   logic [DIGITS-1:0] an;
   logic              bank_wrap;

   int n_cmp;
   int n_err;

   // Reference model state (spec-level view of the display)
   int                  m_bank;
   int                  m_auto;   // auto-mode, non-held cycles since entering auto
   int                  m_n;      // edges since reset release
   logic                m_wrap;
   logic [DIGITS*W-1:0] m_out;
   logic [W-1:0]        m_seg;
   logic [DIGITS-1:0]   m_an;

   led_bank_scanner #(
      .NBANKS(NBANKS), .DIGITS(DIGITS), .W(W), .DWELL(DWELL), .SCAN_DIV(SCAN_DIV)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .mode(mode), .sel(sel),
      .hold(hold), .bank_idx(bank_idx), .out_data(out_data), .seg(seg),
      .an(an), .bank_wrap(bank_wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_bank = 0;
      m_auto = 0;
      m_n    = 0;
      m_wrap = 1'b0;
      m_out  = '0;
      m_seg  = '0;
      m_an   = '1;
   endtask

   task automatic check_outputs(input string tag);
      check_value({tag, ".bank"}, 64'(bank_idx), 64'(m_bank));
      check_value({tag, ".wrap"}, 64'(bank_wrap), 64'(m_wrap));
      check_value({tag, ".out"},  64'(out_data), 64'(m_out));
      check_value({tag, ".seg"},  64'(seg), 64'(m_seg));
      check_value({tag, ".an"},   64'(an), 64'(m_an));
   endtask

   // Asynchronous reset pulse between edges; outputs are checked before any edge.
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_value("rst.bank", 64'(bank_idx), 64'd0);
      check_value("rst.out",  64'(out_data), 64'd0);
      check_value("rst.seg",  64'(seg), 64'd0);
      check_value("rst.an",   64'(an), 64'hF);
      check_value("rst.wrap", 64'(bank_wrap), 64'd0);
      model_reset();
      #1;
      rst_n = 1'b1;
   endtask

   // One clock edge: apply the spec rules to the inputs seen at the edge,
   // then compare every output shortly after the edge.
   task automatic cycle();
      logic             p_mode;
      logic             p_hold;
      logic [BW-1:0]    p_sel;
      logic [DBITS-1:0] p_in;
      int               d;
      p_mode = mode;
      p_hold = hold;
      p_sel  = sel;
      p_in   = in_data;
      @(posedge clk);
      d      = (m_n / SCAN_DIV) % DIGITS;
      m_seg  = m_out[d*W +: W];
      m_an   = ~(4'b0001 << d);
      m_out  = p_in[m_bank*DIGITS*W +: DIGITS*W];
      m_wrap = 1'b0;
      if (!p_mode) begin
         if (int'(p_sel) < NBANKS) m_bank = int'(p_sel);
         m_auto = 0;
      end else if (!p_hold) begin
         m_auto++;
         if (m_auto % DWELL == 0) begin
            m_wrap = (m_bank == NBANKS - 1);
            m_bank = (m_bank + 1) % NBANKS;
         end
      end
      m_n++;
      #1;
      check_outputs("model");
   endtask

   initial begin
      int wraps;
      logic [DBITS-1:0] tmp;
      logic [3:0]       exp_an;
      n_cmp   = 0;
      n_err   = 0;
      rst_n   = 1'b0;
      mode    = 1'b0;
      sel     = '0;
      hold    = 1'b0;
      in_data = {$urandom(), $urandom(), $urandom()};
      model_reset();
      #2;
      do_reset();

      // Manual selection, out-of-range sel ignored
      sel = 2'd2;
      cycle();
      check_value("man.sel2", 64'(bank_idx), 64'd2);
      cycle();
      tmp = in_data;
      check_value("man.out2", 64'(out_data), 64'(tmp[64 +: 32]));
      sel = 2'd3;
      repeat (3) cycle();
      check_value("man.sel3_hold", 64'(bank_idx), 64'd2);

      // Auto rotation from bank 0
      sel = 2'd0;
      cycle();
      mode  = 1'b1;
      wraps = 0;
      for (int k = 1; k <= 30; k++) begin
         cycle();
         if (bank_wrap) wraps++;
         if (k == 9)  check_value("auto.c9",  64'(bank_idx), 64'd0);
         if (k == 10) check_value("auto.c10", 64'(bank_idx), 64'd1);
         if (k == 20) check_value("auto.c20", 64'(bank_idx), 64'd2);
         if (k == 30) begin
            check_value("auto.c30",   64'(bank_idx), 64'd0);
            check_value("auto.wrap30", 64'(bank_wrap), 64'd1);
         end
      end
      check_value("auto.wraps", 64'(wraps), 64'd1);

      // Hold for cycles 5-14 delays the first advance to cycle 20
      do_reset();
      mode = 1'b1;
      for (int k = 1; k <= 22; k++) begin
         hold = (k >= 6 && k <= 15);
         cycle();
         if (k == 19) check_value("hold.c19", 64'(bank_idx), 64'd0);
         if (k == 20) check_value("hold.c20", 64'(bank_idx), 64'd1);
      end
      hold = 1'b0;

      // Scan sequence with digit 0 of bank 0 = 0xC0
      do_reset();
      mode = 1'b0;
      sel  = 2'd0;
      in_data[31:0] = 32'hA4B0F9C0;
      for (int n = 1; n <= 16; n++) begin
         cycle();
         exp_an = ~(4'b0001 << ((n - 1) / 4));
         check_value("scan.an", 64'(an), 64'(exp_an));
         if (n >= 2 && n <= 4) check_value("scan.segC0", 64'(seg), 64'hC0);
      end

      // Reset mid dwell period restarts the full period
      do_reset();
      mode = 1'b1;
      repeat (7) cycle();
      do_reset();
      for (int k = 1; k <= 10; k++) begin
         cycle();
         if (k == 9)  check_value("rstmid.c9",  64'(bank_idx), 64'd0);
         if (k == 10) check_value("rstmid.c10", 64'(bank_idx), 64'd1);
      end

      // Auto -> manual -> auto
      do_reset();
      mode = 1'b1;
      repeat (20) cycle();
      check_value("sw.bank2", 64'(bank_idx), 64'd2);
      mode = 1'b0;
      sel  = 2'd1;
      cycle();
      check_value("sw.man1", 64'(bank_idx), 64'd1);
      mode = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         cycle();
         if (k == 9)  check_value("sw.c9",  64'(bank_idx), 64'd1);
         if (k == 10) check_value("sw.c10", 64'(bank_idx), 64'd2);
      end

      // Randomized traffic against the model
      for (int k = 0; k < 500; k++) begin
         if ($urandom_range(0, 19) == 0) mode = ~mode;
         sel  = 2'($urandom_range(0, 3));
         hold = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 9) == 0) in_data = {$urandom(), $urandom(), $urandom()};
         if ($urandom_range(0, 149) == 0) do_reset();
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/led_bank_scanner.md
LED_BANK_SCANNER -- requirements
Module: led_bank_scanner

Interface
REQ-001 Parameter NBANKS, default 2: number of display banks; SHALL be >= 2.
REQ-002 Parameter DIGITS, default 4: digits per bank; SHALL be >= 1.
REQ-003 Parameter W, default 8: bits per digit pattern.
REQ-004 Parameter DWELL, default 100_000_000: clk cycles per bank in auto mode; SHALL be >= 2.
REQ-005 Parameter SCAN_DIV, default 100_000: clk cycles per digit refresh slot; SHALL be >= 2.
REQ-006 Port clk, input, 1: the only clock; all state is updated on its rising edge.
REQ-007 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-008 Port in_data, input, NBANKS*DIGITS*W: bank b, digit d occupies bits [(b*DIGITS+d)*W +: W].
REQ-009 Port mode, input, 1: 0 = manual bank select, 1 = auto rotation.
REQ-010 Port sel, input, BW = max(1, clog2(NBANKS)): manual bank index.
REQ-011 Port hold, input, 1: freezes auto rotation while high.
REQ-012 Port bank_idx, output, BW: currently displayed bank.
REQ-013 Port out_data, output, DIGITS*W: registered digit patterns of the current bank.
REQ-014 Port seg, output, W: pattern of the digit in the active scan slot.
REQ-015 Port an, output, DIGITS: active-low one-hot digit enable.
REQ-016 Port bank_wrap, output, 1: one-cycle pulse when auto rotation wraps from NBANKS-1 to 0.

Function
REQ-017 Manual mode: bank_idx SHALL load sel on each edge; if sel >= NBANKS, bank_idx SHALL hold its value.
REQ-018 Auto mode: dwell counter SHALL count 0..DWELL-1; on the edge where it equals DWELL-1 and hold=0, the counter SHALL clear and bank_idx SHALL advance by 1.
REQ-019 Auto wrap: advancing from NBANKS-1 SHALL yield bank 0 and assert bank_wrap for exactly that one cycle.
REQ-020 hold=1 in auto mode SHALL freeze the dwell counter and bank_idx; hold SHALL have no effect in manual mode.
REQ-021 Dwell counter SHALL be held at 0 in manual mode; on a manual-to-auto switch, rotation SHALL start from the current bank_idx with a full DWELL period.
REQ-022 Auto-to-manual switch: bank_idx SHALL take sel (subject to REQ-017) on the first edge with mode=0.
REQ-023 out_data SHALL equal the in_data slice for bank_idx, registered, with a 1-cycle latency after a bank_idx or in_data change.
REQ-024 Scan counter SHALL count 0..SCAN_DIV-1 continuously, independent of mode and hold; at SCAN_DIV-1, digit index SHALL advance and wrap DIGITS-1 -> 0.
REQ-025 an SHALL be registered as ~(1 << digit); seg SHALL be registered as out_data digit slice [digit*W +: W].
REQ-026 DIGITS=1: an SHALL stay 0 after reset and the digit index SHALL stay 0.

Reset
REQ-027 rst_n low SHALL immediately force bank_idx=0, out_data=0, seg=0, an=all ones (blank), bank_wrap=0, and clear dwell counter, scan counter and digit index.
REQ-028 Reset asserted mid-rotation or mid-scan SHALL discard all progress; after release, the first auto advance SHALL occur DWELL cycles later.
REQ-029 Reset release SHALL be synchronised to clk outside this block; the block SHALL NOT add its own synchroniser.

Structure
REQ-030 Shared package led_pkg SHALL hold the default parameter constants and a onehot/active-low-decode function.
REQ-031 Sub-module tick_gen (parameter PERIOD; inputs clk, rst_n, en, clr; output tick) SHALL be instantiated twice, once for dwell and once for scan.
REQ-032 The block SHALL contain no combinational path from in_data, sel or mode to any output.

Verification (NBANKS=3, DIGITS=4, W=8, DWELL=10, SCAN_DIV=4)
REQ-033 Reset, then mode=0, sel=2 -> bank_idx=2 after 1 edge; out_data = bank 2 slice after 2 edges; sel=3 -> bank_idx stays 2.
REQ-034 mode=1, hold=0 from bank 0 -> bank_idx 1 at cycle 10, 2 at 20, 0 at 30 with bank_wrap high only at cycle 30.
REQ-035 Auto mode, hold=1 for cycles 5-14 -> first advance delayed to cycle 20; bank_wrap never asserts during hold.
REQ-036 Free-running scan -> an sequence 1110, 1101, 1011, 0111, each for 4 cycles; seg equals the matching out_data byte, e.g. 0xC0 for digit 0 = 0xC0.
REQ-037 rst_n pulsed low at cycle 7 of a dwell period -> all outputs take reset values without waiting for a clock edge; next advance at 10 cycles after release.
REQ-038 Switch mode 1 -> 0 with sel=1 while in bank 2 -> bank_idx=1 on the next edge; switch back -> advance to 2 exactly 10 cycles later.
